// File: rtl/c3lib_cfgcsr_slowfast_pulse_hs.sv
// Slow-to-fast pulse crossing with a 4-phase req/ack handshake.
// Back-to-back slow events queue in a pending counter; busy/overflow status is reported on the slow side.
`timescale 1ns/1ps
module c3lib_cfgcsr_slowfast_pulse_hs #(
  parameter int TRIGGER_POSEDGE = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int PEND_W          = 2
) (
  input  logic i_fastclk,
  input  logic i_fastrstn,
  input  logic i_slowclk,
  input  logic i_slowrstn,
  input  logic i_slowpulse,
  input  logic i_slow_ovf_clr,
  output logic o_slow_busy,
  output logic o_slow_overflow,
  output logic o_fastpulse
);

  localparam logic              IDLE_LVL = (TRIGGER_POSEDGE == 0);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT} state_t;

  state_t                 state;
  logic                   slow_req;
  logic                   r_slowpulse;
  logic                   capture_edge;
  logic                   launch;
  logic                   ovf_set;
  logic                   ack_sync;
  logic [PEND_W-1:0]      pend_cnt;
  logic [PEND_W-1:0]      pend_nxt;
  logic [SYNC_STAGES-1:0] ack_chain;
  logic [SYNC_STAGES-1:0] req_chain;
  logic                   req_sync;
  logic                   r_req_sync;
  logic                   fast_evt;

  assign capture_edge = (r_slowpulse == IDLE_LVL) && (i_slowpulse != IDLE_LVL);
  assign launch       = (state == IDLE) && (capture_edge || (pend_cnt != '0));
  assign ack_sync     = ack_chain[SYNC_STAGES-1];

  // A capture that coincides with a launch cancels out, so the counter only moves on a lone event.
  always_comb begin
    pend_nxt = pend_cnt;
    ovf_set  = 1'b0;
    if (capture_edge && !launch) begin
      if (pend_cnt == PEND_MAX) ovf_set  = 1'b1;
      else                      pend_nxt = pend_cnt + 1'b1;
    end else if (!capture_edge && launch) begin
      pend_nxt = pend_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_slowclk or negedge i_slowrstn) begin
    if (!i_slowrstn) begin
      r_slowpulse     <= IDLE_LVL;
      pend_cnt        <= '0;
      o_slow_overflow <= 1'b0;
    end else begin
      r_slowpulse <= i_slowpulse;
      pend_cnt    <= pend_nxt;
      if (ovf_set)             o_slow_overflow <= 1'b1;
      else if (i_slow_ovf_clr) o_slow_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_slowclk or negedge i_slowrstn) begin
    if (!i_slowrstn) begin
      state       <= IDLE;
      slow_req    <= 1'b0;
      o_slow_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= REQ;
            slow_req    <= 1'b1;
            o_slow_busy <= 1'b1;
          end else begin
            o_slow_busy <= (pend_nxt != '0);
          end
        end
        REQ: begin
          o_slow_busy <= 1'b1;
          if (ack_sync) begin
            state    <= ACKWAIT;
            slow_req <= 1'b0;
          end
        end
        ACKWAIT: begin
          if (!ack_sync) begin
            state       <= IDLE;
            o_slow_busy <= (pend_nxt != '0);
          end else begin
            o_slow_busy <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          slow_req    <= 1'b0;
          o_slow_busy <= (pend_nxt != '0);
        end
      endcase
    end
  end

  // Ack is the fast-side synchronized req, returned through its own slow-domain chain.
  always_ff @(posedge i_slowclk or negedge i_slowrstn) begin
    if (!i_slowrstn) ack_chain <= '0;
    else             ack_chain <= {ack_chain[SYNC_STAGES-2:0], req_sync};
  end

  always_ff @(posedge i_fastclk or negedge i_fastrstn) begin
    if (!i_fastrstn) begin
      req_chain  <= '0;
      r_req_sync <= 1'b0;
    end else begin
      req_chain  <= {req_chain[SYNC_STAGES-2:0], slow_req};
      r_req_sync <= req_sync;
    end
  end

  assign req_sync    = req_chain[SYNC_STAGES-1];
  assign fast_evt    = req_sync && !r_req_sync;
  assign o_fastpulse = fast_evt ^ IDLE_LVL;

endmodule
